// File: rtl/fp16_unpack_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fp16_unpack_if                                                           |
// | Operand-in / unpacked-result-out handshake bundle for fp16_unpack.       |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface fp16_unpack_if;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic        sign_out;
    logic [6:0]  exp_out;
    logic [10:0] norm_out;
    logic        is_zero;
    logic        is_special;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, sign_out, exp_out, norm_out, is_zero, is_special
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, sign_out, exp_out, norm_out, is_zero, is_special
    );
endinterface
`default_nettype wire

// File: rtl/fp16_unpack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | fp16_unpack                                                              |
// | FP16 word -> {sign, 7-bit 2's-complement exp, 11-bit normalized signif}. |
// | Build option: FP16_UNPACK_FAST_NORM_EN selects single-edge subnormal     |
// | renormalization instead of the 1-bit-per-cycle NORM loop.                |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module fp16_unpack (
    input  wire logic    clk,
    input  wire logic    rst_n,
    fp16_unpack_if.slave bus
);

`ifdef FP16_UNPACK_FAST_NORM_EN
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_NORM = 2'd1,
        S_HOLD = 2'd2
    } state_t;
`endif

    state_t      state_q, state_d;
    logic        sign_q, sign_d;
    logic [6:0]  exp_q, exp_d;
    logic [10:0] norm_q, norm_d;
    logic        zero_q, zero_d;
    logic        special_q, special_d;

    logic        in_ready;
    logic        accept;
    logic [4:0]  exp_field;
    logic [9:0]  man;

    assign exp_field = bus.in_data[14:10];
    assign man       = bus.in_data[9:0];

`ifdef FP16_UNPACK_FAST_NORM_EN
    assign in_ready = (state_q != S_HOLD) || bus.out_ready;

    logic [3:0]  sub_shift;
    logic [10:0] sub_norm;

    // Last set bit scanned wins, so sub_shift ends up as 10 - (leading-one index).
    always_comb begin
        sub_shift = 4'd0;
        for (int i = 0; i < 10; i++) begin
            if (man[i]) begin
                sub_shift = 4'(10 - i);
            end
        end
        sub_norm = {1'b0, man} << sub_shift;
    end
`else
    assign in_ready = (state_q == S_IDLE) || ((state_q == S_HOLD) && bus.out_ready);
`endif

    assign accept = bus.in_valid && in_ready;

    always_comb begin
        state_d   = state_q;
        sign_d    = sign_q;
        exp_d     = exp_q;
        norm_d    = norm_q;
        zero_d    = zero_q;
        special_d = special_q;

        case (state_q)
            S_HOLD: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
`ifndef FP16_UNPACK_FAST_NORM_EN
            // norm_q/exp_q double as the shift working registers while out_valid is low.
            S_NORM: begin
                norm_d = {norm_q[9:0], 1'b0};
                exp_d  = exp_q - 7'd1;
                if (norm_q[9]) begin
                    state_d = S_HOLD;
                end
            end
`endif
            default: ;
        endcase

        if (accept) begin
            sign_d    = bus.in_data[15];
            zero_d    = 1'b0;
            special_d = 1'b0;
            state_d   = S_HOLD;
            if (exp_field != 5'd0) begin
                exp_d     = {2'b00, exp_field};
                norm_d    = {1'b1, man};
                special_d = (exp_field == 5'd31);
            end else if (man == 10'd0) begin
                exp_d  = 7'd0;
                norm_d = 11'd0;
                zero_d = 1'b1;
            end else begin
`ifdef FP16_UNPACK_FAST_NORM_EN
                exp_d  = 7'd0 - {3'b000, sub_shift};
                norm_d = sub_norm;
`else
                // The accept edge performs the first shift, giving latency s overall.
                exp_d  = 7'h7F;
                norm_d = {man, 1'b0};
                if (!man[9]) begin
                    state_d = S_NORM;
                end
`endif
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            sign_q    <= 1'b0;
            exp_q     <= 7'd0;
            norm_q    <= 11'd0;
            zero_q    <= 1'b0;
            special_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sign_q    <= sign_d;
            exp_q     <= exp_d;
            norm_q    <= norm_d;
            zero_q    <= zero_d;
            special_q <= special_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = (state_q == S_HOLD);
    assign bus.sign_out   = sign_q;
    assign bus.exp_out    = exp_q;
    assign bus.norm_out   = norm_q;
    assign bus.is_zero    = zero_q;
    assign bus.is_special = special_q;

endmodule
`default_nettype wire

// File: tb/tb_fp16_unpack.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_fp16_unpack                                                           |
// | Randomized + directed bench for fp16_unpack against a latency model.     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module tb_fp16_unpack;

`ifdef FP16_UNPACK_FAST_NORM_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct packed {
        logic        sign;
        logic [6:0]  e;
        logic [10:0] n;
        logic        z;
        logic        sp;
    } res_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fail;
    int   cyc;

    fp16_unpack_if bus ();

    fp16_unpack dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Reference from the number format itself: value = m * 2^-s renormalized.
    function automatic void model(input logic [15:0] w, output res_t r, output int lat);
        int e;
        int m;
        int s;
        int v;
        e      = int'(w[14:10]);
        m      = int'(w[9:0]);
        r.sign = w[15];
        r.z    = 1'b0;
        r.sp   = 1'b0;
        lat    = 1;
        if (e != 0) begin
            r.e  = 7'(e);
            r.n  = 11'(1024 + m);
            r.sp = (e == 31);
        end else if (m == 0) begin
            r.e = 7'd0;
            r.n = 11'd0;
            r.z = 1'b1;
        end else begin
            v = m;
            s = 0;
            while (v < 1024) begin
                v = v * 2;
                s++;
            end
            r.e = 7'(-s);
            r.n = 11'(v);
            lat = FAST ? 1 : s;
        end
    endfunction

    // Model state: result shown on the outputs, or a pending one counting down.
    logic m_valid;
    int   m_cnt;
    res_t m_res;
    res_t m_pend;

    always @(negedge clk) begin
        logic exp_rdy;
        logic acc;
        logic xfer;
        res_t r;
        int   lat;
        if (!rst_n) begin
            m_valid = 1'b0;
            m_cnt   = 0;
            check("reset_outputs",
                  32'({bus.out_valid, bus.sign_out, bus.exp_out, bus.norm_out, bus.is_zero, bus.is_special}),
                  32'd0);
        end else begin
            exp_rdy = (!m_valid && m_cnt == 0) || (m_valid && bus.out_ready);
            check("in_ready", 32'(bus.in_ready), 32'(exp_rdy));
            check("out_valid", 32'(bus.out_valid), 32'(m_valid));
            if (m_valid) begin
                check("result",
                      32'({bus.sign_out, bus.exp_out, bus.norm_out, bus.is_zero, bus.is_special}),
                      32'(m_res));
            end
            acc  = bus.in_valid && exp_rdy;
            xfer = m_valid && bus.out_ready;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_valid = 1'b1;
                    m_res   = m_pend;
                end
            end else if (xfer) begin
                m_valid = 1'b0;
            end
            if (acc) begin
                model(bus.in_data, r, lat);
                if (lat == 1) begin
                    m_valid = 1'b1;
                    m_res   = r;
                end else begin
                    m_cnt  = lat - 1;
                    m_pend = r;
                end
            end
        end
    end

    task automatic send(input logic [15:0] w);
        bit done;
        done         = 1'b0;
        bus.in_valid = 1'b1;
        bus.in_data  = w;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (bus.in_ready) begin
                @(posedge clk);
                #1;
                done = 1'b1;
            end
        end
        bus.in_valid = 1'b0;
        if (!done) check("send_timeout", 32'd0, 32'd1);
    endtask

    initial begin
        res_t r;
        int   lat;
        int   t0;
        int   edges;
        logic acc;

        n_checks      = 0;
        n_fail        = 0;
        cyc           = 0;
        rst_n         = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_data   = 16'h0000;
        bus.out_ready = 1'b1;
        #1 rst_n = 1'b0;

        // Pin the model against hand-computed values.
        model(16'h3C00, r, lat);
        check("pin_3c00", 32'({r, 8'(lat)}), 32'({1'b0, 7'h0F, 11'h400, 1'b0, 1'b0, 8'd1}));
        model(16'h0001, r, lat);
        check("pin_0001", 32'({r, 8'(lat)}), 32'({1'b0, 7'h76, 11'h400, 1'b0, 1'b0, FAST ? 8'd1 : 8'd10}));
        model(16'h8200, r, lat);
        check("pin_8200", 32'({r, 8'(lat)}), 32'({1'b1, 7'h7F, 11'h400, 1'b0, 1'b0, 8'd1}));
        model(16'h8000, r, lat);
        check("pin_8000", 32'(r), 32'({1'b1, 7'h00, 11'h000, 1'b1, 1'b0}));
        model(16'h7C00, r, lat);
        check("pin_7c00", 32'(r), 32'({1'b0, 7'h1F, 11'h400, 1'b0, 1'b1}));

        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Back-to-back normals: one accept per cycle.
        t0 = cyc;
        send(16'h3C00);
        send(16'h4000);
        send(16'hC500);
        send(16'h3555);
        check("throughput_cycles", 32'(cyc - t0), 32'd4);

        // Smallest subnormal, latency measured edge by edge.
        @(posedge clk); #1;
        send(16'h0001);
        edges = 1;
        for (int k = 0; k < 20 && !bus.out_valid; k++) begin
            @(posedge clk); #1;
            edges++;
        end
        check("sub_latency", 32'(edges), FAST ? 32'd1 : 32'd10);
        check("sub_exp", 32'(bus.exp_out), 32'h76);

        send(16'h8200);
        check("neg_sub_exp", 32'({bus.out_valid, bus.sign_out, bus.exp_out}), 32'({1'b1, 1'b1, 7'h7F}));
        send(16'h8000);
        send(16'h7C00);
        check("inf_flags", 32'({bus.is_special, bus.exp_out, bus.norm_out}), 32'({1'b1, 7'h1F, 11'h400}));

        // Backpressure, then same-edge transfer and accept.
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        send(16'h3C00);
        repeat (5) @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        send(16'h4000);
        check("bp_next_exp", 32'({bus.out_valid, bus.exp_out}), 32'({1'b1, 7'h10}));

        // Reset while a subnormal is in flight.
        @(posedge clk); #1;
        send(16'h0001);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_async_valid", 32'({bus.out_valid, bus.exp_out, bus.norm_out}), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        send(16'h3C00);
        check("post_rst_result", 32'({bus.out_valid, bus.exp_out, bus.norm_out}), 32'({1'b1, 7'h0F, 11'h400}));

        // Randomized traffic; upstream holds its word until accepted.
        for (int k = 0; k < 1500; k++) begin
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc || !bus.in_valid) begin
                bus.in_valid = ($urandom_range(0, 3) != 0);
                case ($urandom_range(0, 3))
                    0:       bus.in_data = {1'($urandom), 5'd0, 10'($urandom)};
                    1:       bus.in_data = {1'($urandom), 5'd0, 10'(1 << $urandom_range(0, 9))};
                    2:       bus.in_data = {1'($urandom), 5'd31, 10'($urandom)};
                    default: bus.in_data = 16'($urandom);
                endcase
            end
            bus.out_ready = ($urandom_range(0, 9) < 7);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        repeat (15) @(posedge clk);
        @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, expected completion before %0t", $time);
        $fatal(1);
    end

endmodule
`default_nettype wire
